// File: rtl/ppfifo_to_axis_video_if.sv
// Block FIFO read port plus AXI4-Stream video output of ppfifo_to_axis_video.
// The master modport is the converter; the slave modport is the FIFO/stream environment.
interface ppfifo_to_axis_video_if #(
    parameter int FIFO_SIZE_WIDTH = 24
);
    logic                       i_rfifo_ready;
    logic                       o_rfifo_activate;
    logic                       o_rfifo_strobe;
    logic [24:0]                i_rfifo_data;
    logic [FIFO_SIZE_WIDTH-1:0] i_rfifo_size;
    logic                       o_axis_tvalid;
    logic                       i_axis_tready;
    logic [23:0]                o_axis_tdata;
    logic                       o_axis_tuser;
    logic                       o_axis_tlast;

    modport master (
        input  i_rfifo_ready, i_rfifo_data, i_rfifo_size, i_axis_tready,
        output o_rfifo_activate, o_rfifo_strobe,
        output o_axis_tvalid, o_axis_tdata, o_axis_tuser, o_axis_tlast
    );

    modport slave (
        output i_rfifo_ready, i_rfifo_data, i_rfifo_size, i_axis_tready,
        input  o_rfifo_activate, o_rfifo_strobe,
        input  o_axis_tvalid, o_axis_tdata, o_axis_tuser, o_axis_tlast
    );
endinterface

// File: rtl/ppfifo_to_axis_video.sv
// Drains ping-pong block FIFO lines into an AXI4-Stream video master (RGB332 -> RGB888).
// Optional PPFIFO_AXIS_SOF_SYNC_EN: discard words until the first SOF after reset / enable rise.
//
// state       | meaning
// ST_IDLE     | waiting for enable and a ready block
// ST_ACTIVATE | block held, word 0 not yet on the bus
// ST_READ     | popping words into the skid buffer
// ST_RELEASE  | dropping activate, back to idle next cycle
module ppfifo_to_axis_video #(
    parameter int FIFO_SIZE_WIDTH = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_busy,
    ppfifo_to_axis_video_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVATE,
        ST_READ,
        ST_RELEASE
    } state_t;

    localparam logic [FIFO_SIZE_WIDTH-1:0] ONE = 1;

    state_t                     state;
    logic                       activate;
    logic [FIFO_SIZE_WIDTH-1:0] size_q;
    logic [FIFO_SIZE_WIDTH-1:0] count;
    logic [1:0]                 skid_cnt;
    logic [25:0]                head;
    logic [25:0]                spare;
    logic                       strobe;
    logic                       push;
    logic                       pop;
    logic                       last_word;
    logic [2:0]                 r3;
    logic [2:0]                 g3;
    logic [1:0]                 b2;
    logic [25:0]                word_x;

    wire unused_data_hi = &{1'b0, bus.i_rfifo_data[24:9]};

    // Strobe depends only on registers, so tready never reaches the FIFO read port combinationally.
    assign strobe    = (state == ST_READ) && (skid_cnt != 2'd2);
    assign last_word = (count == (size_q - ONE));
    assign pop       = (skid_cnt != 2'd0) && bus.i_axis_tready;

    assign r3     = bus.i_rfifo_data[7:5];
    assign g3     = bus.i_rfifo_data[4:2];
    assign b2     = bus.i_rfifo_data[1:0];
    assign word_x = {last_word, bus.i_rfifo_data[8],
                     r3, r3, r3[2:1], g3, g3, g3[2:1], b2, b2, b2, b2};

`ifdef PPFIFO_AXIS_SOF_SYNC_EN
    logic sync_wait;
    logic enable_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_wait <= 1'b1;
            enable_d  <= 1'b0;
        end else begin
            enable_d <= i_enable;
            if (strobe && bus.i_rfifo_data[8])
                sync_wait <= 1'b0;
            else if (i_enable && !enable_d)
                sync_wait <= 1'b1;
        end
    end

    assign push = strobe && (!sync_wait || bus.i_rfifo_data[8]);
`else
    assign push = strobe;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            activate <= 1'b0;
            size_q   <= '0;
            count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_enable && bus.i_rfifo_ready && !activate) begin
                        activate <= 1'b1;
                        size_q   <= bus.i_rfifo_size;
                        count    <= '0;
                        state    <= ST_ACTIVATE;
                    end
                end
                ST_ACTIVATE: begin
                    state <= (size_q == '0) ? ST_RELEASE : ST_READ;
                end
                ST_READ: begin
                    if (strobe) begin
                        count <= count + ONE;
                        if (last_word)
                            state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    activate <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // head drives the AXIS outputs directly; spare only fills while head is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_cnt <= 2'd0;
            head     <= '0;
            spare    <= '0;
        end else begin
            case (skid_cnt)
                2'd0: begin
                    if (push) begin
                        head     <= word_x;
                        skid_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= word_x;
                    end else if (push) begin
                        spare    <= word_x;
                        skid_cnt <= 2'd2;
                    end else if (pop) begin
                        skid_cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head     <= spare;
                        skid_cnt <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign bus.o_rfifo_activate = activate;
    assign bus.o_rfifo_strobe   = strobe;
    assign bus.o_axis_tvalid    = (skid_cnt != 2'd0);
    assign bus.o_axis_tdata     = head[23:0];
    assign bus.o_axis_tuser     = head[24];
    assign bus.o_axis_tlast     = head[25];
    assign o_busy               = activate || (skid_cnt != 2'd0);
endmodule

// File: tb/tb_ppfifo_to_axis_video.sv
// Directed bench for ppfifo_to_axis_video: block FIFO model, AXIS beat monitor, vector table.
module tb_ppfifo_to_axis_video;
    logic clk = 1'b0;
    logic rst;
    logic i_enable;
    logic o_busy;
    logic tready;
    logic model_clr;
    logic mon_clr;
    int   nblk;

    always #5 clk = ~clk;

    ppfifo_to_axis_video_if #(.FIFO_SIZE_WIDTH(24)) bus ();

    ppfifo_to_axis_video #(.FIFO_SIZE_WIDTH(24)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_enable (i_enable),
        .o_busy   (o_busy),
        .bus      (bus)
    );

    logic [24:0] mem      [0:3][0:511];
    logic [23:0] size_tab [0:3];

    int         blk_ptr, act_rises, strobe_cnt, over_strobe, cyc;
    int         last_strobe_cyc, gap, hi_cnt, act_len;
    logic [1:0] cur_blk;
    logic [8:0] rd_idx;
    logic       act_d;

    assign bus.i_rfifo_ready = !model_clr && (blk_ptr < nblk);
    assign bus.i_rfifo_size  = size_tab[blk_ptr[1:0]];
    assign bus.i_rfifo_data  = mem[cur_blk][rd_idx];
    assign bus.i_axis_tready = tready;

    // Block FIFO read-side model: word k presented after activation / k strobes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (model_clr) begin
            blk_ptr     <= 0;
            cur_blk     <= 2'd0;
            rd_idx      <= 9'd0;
            strobe_cnt  <= 0;
            act_rises   <= 0;
            over_strobe <= 0;
            act_d       <= 1'b0;
        end else begin
            act_d <= bus.o_rfifo_activate;
            if (bus.o_rfifo_activate && !act_d) begin
                cur_blk   <= blk_ptr[1:0];
                blk_ptr   <= blk_ptr + 1;
                rd_idx    <= 9'd0;
                act_rises <= act_rises + 1;
                gap       <= cyc - last_strobe_cyc;
                hi_cnt    <= 1;
            end else if (bus.o_rfifo_activate) begin
                hi_cnt <= hi_cnt + 1;
            end
            if (!bus.o_rfifo_activate && act_d)
                act_len <= hi_cnt;
            if (bus.o_rfifo_strobe) begin
                rd_idx          <= rd_idx + 9'd1;
                strobe_cnt      <= strobe_cnt + 1;
                last_strobe_cyc <= cyc;
                if (!bus.o_rfifo_activate || int'(rd_idx) >= int'(size_tab[cur_blk]))
                    over_strobe <= over_strobe + 1;
            end
        end
    end

    logic [25:0] beats [0:511];
    int          beat_n;
    int          stab_err = 0;
    logic        tvalid_seen;
    logic        stall_d;
    logic [25:0] held;
    wire  [25:0] cur_beat = {bus.o_axis_tlast, bus.o_axis_tuser, bus.o_axis_tdata};

    always @(negedge clk) begin
        if (mon_clr) begin
            beat_n      <= 0;
            tvalid_seen <= 1'b0;
            stall_d     <= 1'b0;
        end else begin
            if (bus.o_axis_tvalid)
                tvalid_seen <= 1'b1;
            if (bus.o_axis_tvalid && tready && beat_n < 512) begin
                beats[beat_n] <= cur_beat;
                beat_n        <= beat_n + 1;
            end
            if (!rst && stall_d && (!bus.o_axis_tvalid || cur_beat != held))
                stab_err <= stab_err + 1;
            stall_d <= bus.o_axis_tvalid && !tready && !rst;
            held    <= cur_beat;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [23:0] expand(input logic [24:0] w);
        logic [7:0] r, g, b;
        r = ({5'd0, w[7:5]} << 5) | ({5'd0, w[7:5]} << 2) | ({5'd0, w[7:5]} >> 1);
        g = ({5'd0, w[4:2]} << 5) | ({5'd0, w[4:2]} << 2) | ({5'd0, w[4:2]} >> 1);
        b = {6'd0, w[1:0]} * 8'h55;
        return {r, g, b};
    endfunction

    task automatic start_blocks(input int n);
        model_clr = 1'b1;
        mon_clr   = 1'b1;
        nblk      = n;
        @(posedge clk); #1;
        model_clr = 1'b0;
        mon_clr   = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input bit rnd);
        int c = 0;
        while (beat_n < n && c < budget) begin
            @(posedge clk); #1;
            if (rnd) tready = 1'($urandom_range(0, 1));
            c++;
        end
        tready = 1'b1;
        chk("beat_timeout", (beat_n >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Compares n beats starting at beats[base] against block blk; returns the error count.
    function automatic int block_errs(input int blk, input int n, input int base);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (beats[base+i] !== {(i == n - 1), mem[blk][i][8], expand(mem[blk][i])})
                e++;
        end
        return e;
    endfunction

    typedef struct {
        logic [24:0] word;
        logic [23:0] exp_data;
        logic        exp_user;
    } vec_t;

    vec_t tab [8];

    initial begin
        tab[0] = '{25'h00001FF, 24'hFFFFFF, 1'b1};
        tab[1] = '{25'h00000E0, 24'hFF0000, 1'b0};
        tab[2] = '{25'h000001C, 24'h00FF00, 1'b0};
        tab[3] = '{25'h0000003, 24'h0000FF, 1'b0};
        tab[4] = '{25'h00000A4, 24'hB62400, 1'b0};
        tab[5] = '{25'h0000149, 24'h494955, 1'b1};
        tab[6] = '{25'h0000012, 24'h0092AA, 1'b0};
        tab[7] = '{25'h1FFFE00, 24'h000000, 1'b0};

        cyc = 0; last_strobe_cyc = 0; gap = 0; hi_cnt = 0; act_len = 0;
        rst = 1'b1; i_enable = 1'b0; tready = 1'b0;
        model_clr = 1'b1; mon_clr = 1'b1; nblk = 0;
        for (int b = 0; b < 4; b++) begin
            size_tab[b] = 24'd0;
            for (int i = 0; i < 512; i++) mem[b][i] = 25'd0;
        end
        repeat (3) @(posedge clk); #1;

        chk("rst_activate", {31'd0, bus.o_rfifo_activate}, 32'd0);
        chk("rst_strobe",   {31'd0, bus.o_rfifo_strobe},   32'd0);
        chk("rst_tvalid",   {31'd0, bus.o_axis_tvalid},    32'd0);
        chk("rst_tdata",    {8'd0, bus.o_axis_tdata},      32'd0);
        chk("rst_tuser",    {31'd0, bus.o_axis_tuser},     32'd0);
        chk("rst_tlast",    {31'd0, bus.o_axis_tlast},     32'd0);
        chk("rst_busy",     {31'd0, o_busy},               32'd0);
        rst = 1'b0; model_clr = 1'b0; mon_clr = 1'b0;
        tready = 1'b1; i_enable = 1'b1;

`ifndef PPFIFO_AXIS_SOF_SYNC_EN
        // Vector table: a size-4 line with latency checks, then the full 8-word line.
        for (int pass = 0; pass < 2; pass++) begin
            int n;
            n = (pass == 0) ? 4 : 8;
            size_tab[0] = 24'(n);
            for (int i = 0; i < n; i++) mem[0][i] = tab[i].word;
            start_blocks(1);
            @(posedge clk); #1;
            chk("ready_to_activate", {31'd0, bus.o_rfifo_activate}, 32'd1);
            @(posedge clk); #1;
            chk("tvalid_early", {31'd0, bus.o_axis_tvalid}, 32'd0);
            @(posedge clk); #1;
            chk("activate_to_tvalid", {31'd0, bus.o_axis_tvalid}, 32'd1);
            wait_beats(n, 50, 1'b0);
            repeat (4) @(posedge clk); #1;
            for (int i = 0; i < n; i++) begin
                chk("vec_tdata", {8'd0, beats[i][23:0]}, {8'd0, tab[i].exp_data});
                chk("vec_tuser", {31'd0, beats[i][24]}, {31'd0, tab[i].exp_user});
                chk("vec_tlast", {31'd0, beats[i][25]}, (i == n - 1) ? 32'd1 : 32'd0);
            end
            chk("vec_beats",   beat_n, n);
            chk("vec_strobes", strobe_cnt, n);
            chk("vec_act_len", act_len, n + 2);
            chk("vec_idle",    {30'd0, bus.o_rfifo_activate, o_busy}, 32'd0);
        end

        // 256-word line with random backpressure.
        size_tab[0] = 24'd256;
        for (int i = 0; i < 256; i++)
            mem[0][i] = {16'hA5A5 ^ 16'(i), (i == 0), 8'(i * 37)};
        start_blocks(1);
        wait_beats(256, 3000, 1'b1);
        repeat (4) @(posedge clk); #1;
        chk("long_beats",   beat_n, 256);
        chk("long_content", block_errs(0, 256, 0), 0);
        chk("long_strobes", strobe_cnt, 256);
        chk("long_stable",  stab_err, 0);

        // Size-0 line, then two back-to-back size-2 lines.
        size_tab[0] = 24'd0;
        size_tab[1] = 24'd2;
        size_tab[2] = 24'd2;
        for (int i = 0; i < 2; i++) begin
            mem[1][i] = {16'h1234, (i == 0), 8'(8'h5A + i)};
            mem[2][i] = {16'h0, 1'b0, 8'(8'hC3 - i)};
        end
        start_blocks(1);
        repeat (10) @(posedge clk); #1;
        chk("zero_act_len", act_len, 2);
        chk("zero_no_tvalid", {31'd0, tvalid_seen}, 32'd0);
        chk("zero_rises", act_rises, 1);
        chk("zero_idle", {30'd0, bus.o_rfifo_activate, o_busy}, 32'd0);
        nblk = 3;
        wait_beats(4, 60, 1'b0);
        repeat (4) @(posedge clk); #1;
        chk("b2b_first",  block_errs(1, 2, 0), 0);
        chk("b2b_second", block_errs(2, 2, 2), 0);
        chk("b2b_gap", (gap >= 3) ? 32'd1 : 32'd0, 32'd1);
        chk("b2b_rises", act_rises, 3);

        // Reset in the middle of a 64-word line, then a fresh 3-word line.
        size_tab[0] = 24'd64;
        size_tab[1] = 24'd3;
        for (int i = 0; i < 64; i++) mem[0][i] = {16'h0, (i == 0), 8'(i)};
        for (int i = 0; i < 3; i++)  mem[1][i] = {16'h0, (i == 0), 8'(8'h30 + i)};
        start_blocks(2);
        begin
            int c = 0;
            while (strobe_cnt < 10 && c < 100) begin
                @(posedge clk); #1;
                c++;
            end
            chk("rst_wait_timeout", (strobe_cnt >= 10) ? 32'd1 : 32'd0, 32'd1);
        end
        rst = 1'b1;
        i_enable = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_outputs",
            {25'd0, bus.o_rfifo_activate, bus.o_rfifo_strobe, bus.o_axis_tvalid,
             bus.o_axis_tuser, bus.o_axis_tlast, o_busy, (bus.o_axis_tdata != 24'd0)}, 32'd0);
        rst = 1'b0;
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
        i_enable = 1'b1;
        wait_beats(3, 50, 1'b0);
        repeat (4) @(posedge clk); #1;
        chk("post_rst_beats", beat_n, 3);
        chk("post_rst_content", block_errs(1, 3, 0), 0);

        // Enable drops during the first of two ready lines.
        size_tab[0] = 24'd5;
        size_tab[1] = 24'd5;
        for (int i = 0; i < 5; i++) begin
            mem[0][i] = {16'h0, (i == 0), 8'(8'h10 + i)};
            mem[1][i] = {16'h0, (i == 0), 8'(8'h80 + i)};
        end
        start_blocks(2);
        @(posedge clk); #1;
        chk("en_activate", {31'd0, bus.o_rfifo_activate}, 32'd1);
        i_enable = 1'b0;
        repeat (40) @(posedge clk); #1;
        chk("en_first_beats", beat_n, 5);
        chk("en_first_content", block_errs(0, 5, 0), 0);
        chk("en_held_off", act_rises, 1);
        chk("en_idle", {30'd0, bus.o_rfifo_activate, o_busy}, 32'd0);
        i_enable = 1'b1;
        wait_beats(10, 60, 1'b0);
        repeat (4) @(posedge clk); #1;
        chk("en_second_content", block_errs(1, 5, 5), 0);
        chk("en_rises", act_rises, 2);
`else
        // SOF sync: a line without SOF is popped and dropped, the next line starts the stream.
        size_tab[0] = 24'd4;
        size_tab[1] = 24'd3;
        for (int i = 0; i < 4; i++) mem[0][i] = {16'h0, 1'b0, 8'(8'h21 + i)};
        for (int i = 0; i < 3; i++) mem[1][i] = {16'h0, (i == 0), 8'(8'h61 + i)};
        start_blocks(2);
        wait_beats(3, 80, 1'b0);
        repeat (4) @(posedge clk); #1;
        chk("sync_beats", beat_n, 3);
        chk("sync_first_tuser", {31'd0, beats[0][24]}, 32'd1);
        chk("sync_content", block_errs(1, 3, 0), 0);
        chk("sync_strobes", strobe_cnt, 7);
        chk("sync_rises", act_rises, 2);
`endif

        chk("no_over_strobe", over_strobe, 0);
        chk("axis_stable", stab_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ppfifo_to_axis_video.md
# ppfifo_to_axis_video

Read-side companion to the NES video capture path: drains ping-pong block FIFO blocks (one video line per block, 25-bit words carrying SOF flag and RGB332 pixel) and emits them as an AXI4-Stream video master. Expands RGB332 to RGB888, marks SOF with `tuser` and end-of-line with `tlast`. Sits in the `axis_clk` domain between the block FIFO read port and the AXI video DMA/VDMA.

## Interface
Parameters:
- `FIFO_SIZE_WIDTH`, 24, width of block FIFO read count.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  stream/read clock (block FIFO read clock)
- `rst`  in  1  synchronous active-high reset
- `i_enable`  in  1  allow new blocks to be activated
- `i_rfifo_ready`  in  1  block available for read
- `o_rfifo_activate`  out  1  holds current block
- `o_rfifo_strobe`  out  1  pop current word
- `i_rfifo_data`  in  25  word: [8]=SOF, [7:5]=R, [4:2]=G, [1:0]=B, [24:9] ignored
- `i_rfifo_size`  in  FIFO_SIZE_WIDTH  words in activated block
- `o_axis_tvalid`  out  1  stream valid
- `i_axis_tready`  in  1  stream ready
- `o_axis_tdata`  out  24  {R8,G8,B8}
- `o_axis_tuser`  out  1  start of frame
- `o_axis_tlast`  out  1  last pixel of line (block)
- `o_busy`  out  1  block activated or skid not empty

## Operation
- Block FIFO word semantics: word k valid on `i_rfifo_data` the cycle after activation (k=0) and the cycle after each strobe.
- FSM: IDLE -> ACTIVATE -> READ -> RELEASE -> IDLE.
  - IDLE: `i_enable && i_rfifo_ready && !o_rfifo_activate` -> assert activate, latch size, count=0, go ACTIVATE.
  - ACTIVATE: one wait cycle for word 0; if latched size==0 go RELEASE (no stream output).
  - READ: when skid has a free slot, capture word, strobe, count++; on count==size-1 capture, tag tlast, go RELEASE.
  - RELEASE: deassert activate; IDLE next cycle.
- Two-entry skid buffer between FIFO and AXIS output; full throughput of one pixel/clock with `tready` held high.
- Color expansion by bit replication: R8={R,R,R[2:1]}, G8={G,G,G[2:1]}, B8={B,B,B,B}.
- `tuser` = word bit 8; `tlast` = last word of block.
- AXIS rules: tdata/tuser/tlast stable while `tvalid && !tready`; tvalid never drops without a handshake.
- `i_enable` low mid-block: current block finishes and drains; no new activation.

## Timing
- Reset: `o_rfifo_activate`, `o_rfifo_strobe`, `o_axis_tvalid`, `o_axis_tdata`, `o_axis_tuser`, `o_axis_tlast`, `o_busy` all 0; skid emptied; FSM IDLE.
- Reset mid-block: activate drops in the cycle after `rst`; partial line discarded.
- `i_rfifo_ready` -> `o_rfifo_activate`: 1 clock. Activate -> first `tvalid`: 2 clocks.
- Strobe is single-cycle per word; never strobes when count==size or skid full.
- Back-to-back blocks: minimum 2 idle-read cycles (RELEASE, IDLE) between last strobe and next activate.
- Size=1 block: single beat with tuser per data and tlast=1.

## Configuration
- `PPFIFO_AXIS_SOF_SYNC_EN`: defined -> after reset and each `i_enable` rising edge, words are popped and discarded (no `tvalid`) until a word with bit 8 set is seen; that word and all later are forwarded. Not defined -> every word is forwarded unconditionally.

## Test plan
- Single block size 4, words 0x1FF,0x0E0,0x01C,0x003, tready=1 -> beats 0xFFFFFF(tuser=1),0xFF0000,0x00FF00,0x0000FF(tlast=1), 4 strobes, activate drops.
- Size 256, tready toggling 50% random -> 256 beats in order, tdata stable while stalled, exactly one tlast, no lost/dup words.
- Size 0 block -> activate high 2 cycles, no tvalid, FSM returns IDLE, next block handled normally.
- Reset asserted at word 10 of 64 -> all outputs 0 next cycle, activate released, next block starts at count 0.
- `i_enable` low during block 1 of 2 ready blocks -> block 1 completes with tlast, block 2 not activated until enable high.
- With `PPFIFO_AXIS_SOF_SYNC_EN`: first block words without SOF then block with SOF at word 0 -> first block fully popped with no beats; first beat has tuser=1.
